// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums STB/ACK product beats into frames and emits a widened sum
// Frame closes on I_LAST; the result is held until O_ACK, and no beats are taken while it is held.
module product_accumulator #(
  parameter int P_WIDTH   = 64,
  parameter int GUARD     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       I_STB,
  output logic                       I_ACK,
  input  logic [P_WIDTH-1:0]         I_DAT,
  input  logic                       I_LAST,
  output logic                       O_STB,
  output logic [P_WIDTH+GUARD-1:0]   O_DAT,
  output logic [CNT_WIDTH-1:0]       O_CNT,
  output logic                       O_OVF,
  input  logic                       O_ACK
);

  localparam int S_WIDTH = P_WIDTH + GUARD;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [S_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 first_q, first_d;
  logic                 o_stb_q, o_stb_d;
  logic [S_WIDTH-1:0]   o_dat_q, o_dat_d;
  logic [CNT_WIDTH-1:0] o_cnt_q, o_cnt_d;
  logic                 o_ovf_q, o_ovf_d;
  logic [S_WIDTH:0]     sum_w;
  logic                 xfer;

  always_comb begin
    // o_stb_q doubles as the state: 0 = ACC, 1 = HOLD
    xfer    = RST & I_STB & ~o_stb_q;
    sum_w   = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, I_DAT};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    o_stb_d = o_stb_q;
    o_dat_d = o_dat_q;
    o_cnt_d = o_cnt_q;
    o_ovf_d = o_ovf_q;
    if (xfer) begin
      if (first_q) begin
        acc_d = {{GUARD{1'b0}}, I_DAT};
        cnt_d = CNT_ONE;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_w[S_WIDTH-1:0];
        ovf_d = ovf_q | sum_w[S_WIDTH];
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
      first_d = I_LAST;
      if (I_LAST) begin
        o_dat_d = acc_d;
        o_cnt_d = cnt_d;
        o_ovf_d = ovf_d;
        o_stb_d = 1'b1;
      end
    end else if (o_stb_q && O_ACK) begin
      o_stb_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      o_stb_q <= 1'b0;
      o_dat_q <= '0;
      o_cnt_q <= '0;
      o_ovf_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
      o_stb_q <= o_stb_d;
      o_dat_q <= o_dat_d;
      o_cnt_q <= o_cnt_d;
      o_ovf_q <= o_ovf_d;
    end
  end

  assign I_ACK = xfer;
  assign O_STB = o_stb_q;
  assign O_DAT = o_dat_q;
  assign O_CNT = o_cnt_q;
  assign O_OVF = o_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
module tb_product_accumulator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_STB;
  logic        I_ACK;
  logic [63:0] I_DAT;
  logic        I_LAST;
  logic        O_STB;
  logic [71:0] O_DAT;
  logic [15:0] O_CNT;
  logic        O_OVF;
  logic        O_ACK;

  typedef struct packed {
    logic [71:0] dat;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  product_accumulator #(.P_WIDTH(64), .GUARD(8), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .I_STB(I_STB), .I_ACK(I_ACK), .I_DAT(I_DAT), .I_LAST(I_LAST),
    .O_STB(O_STB), .O_DAT(O_DAT), .O_CNT(O_CNT), .O_OVF(O_OVF), .O_ACK(O_ACK)
  );

  always #5 CLK = ~CLK;

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic send_beat(input logic [63:0] dat, input logic last);
    bit done = 0;
    I_STB = 1'b1; I_DAT = dat; I_LAST = last;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (I_ACK === 1'b1) done = 1;
      @(posedge CLK); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: I_ACK=%b required 1", I_ACK);
    end
  endtask

  // Waits (bounded) for O_STB; returns positioned at a negedge.
  task automatic wait_result(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge CLK);
      if (O_STB === 1'b1) ok = 1;
    end
  endtask

  task automatic do_ack();
    O_ACK = 1'b1;
    @(posedge CLK); #1;
    O_ACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; I_STB = 1'b1; I_DAT = 64'd77; I_LAST = 1'b1; O_ACK = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks += 5;
      if (I_ACK !== 1'b0) begin errors++; $display("FAIL reset_i_ack: got %b required 0", I_ACK); end
      if (O_STB !== 1'b0) begin errors++; $display("FAIL reset_o_stb: got %b required 0", O_STB); end
      if (O_DAT !== 72'd0) begin errors++; $display("FAIL reset_o_dat: got %h required 0", O_DAT); end
      if (O_CNT !== 16'd0) begin errors++; $display("FAIL reset_o_cnt: got %0d required 0", O_CNT); end
      if (O_OVF !== 1'b0) begin errors++; $display("FAIL reset_o_ovf: got %b required 0", O_OVF); end
    end
    I_STB = 1'b0; I_LAST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_basic_frame();
    res_t exp;
    sb.push_back('{dat: 72'd23, cnt: 16'd3, ovf: 1'b0});
    send_beat(64'd5, 1'b0);
    send_beat(64'd7, 1'b0);
    send_beat(64'd11, 1'b1);
    I_STB = 1'b0; I_LAST = 1'b0;
    @(negedge CLK);
    checks++;
    if (O_STB !== 1'b1) begin errors++; $display("FAIL basic_latency: O_STB=%b required 1", O_STB); end
    exp = sb.pop_front();
    checks += 3;
    if (O_DAT !== exp.dat) begin errors++; $display("FAIL basic_dat: got %h required %h", O_DAT, exp.dat); end
    if (O_CNT !== exp.cnt) begin errors++; $display("FAIL basic_cnt: got %0d required %0d", O_CNT, exp.cnt); end
    if (O_OVF !== exp.ovf) begin errors++; $display("FAIL basic_ovf: got %b required %b", O_OVF, exp.ovf); end
    do_ack();
  endtask

  task automatic test_single_beat();
    res_t exp;
    bit ok;
    sb.push_back('{dat: 72'h00_FFFF_FFFF_FFFF_FFFF, cnt: 16'd1, ovf: 1'b0});
    send_beat(ALL_ONES, 1'b1);
    I_STB = 1'b0; I_LAST = 1'b0;
    wait_result(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: O_STB=%b required 1", O_STB); end
    exp = sb.pop_front();
    checks += 3;
    if (O_DAT !== exp.dat) begin errors++; $display("FAIL single_dat: got %h required %h", O_DAT, exp.dat); end
    if (O_CNT !== exp.cnt) begin errors++; $display("FAIL single_cnt: got %0d required %0d", O_CNT, exp.cnt); end
    if (O_OVF !== exp.ovf) begin errors++; $display("FAIL single_ovf: got %b required %b", O_OVF, exp.ovf); end
    do_ack();
  endtask

  task automatic test_backpressure();
    res_t exp;
    bit ok;
    sb.push_back('{dat: 72'd300, cnt: 16'd2, ovf: 1'b0});
    send_beat(64'd100, 1'b0);
    send_beat(64'd200, 1'b1);
    // keep offering the next frame's beat while the result is pending
    I_STB = 1'b1; I_DAT = 64'd4; I_LAST = 1'b1;
    wait_result(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: O_STB=%b required 1", O_STB); end
    exp = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks += 5;
      if (I_ACK !== 1'b0) begin errors++; $display("FAIL bp_i_ack: cycle %0d got %b required 0", c, I_ACK); end
      if (O_STB !== 1'b1) begin errors++; $display("FAIL bp_o_stb: cycle %0d got %b required 1", c, O_STB); end
      if (O_DAT !== exp.dat) begin errors++; $display("FAIL bp_dat: cycle %0d got %h required %h", c, O_DAT, exp.dat); end
      if (O_CNT !== exp.cnt) begin errors++; $display("FAIL bp_cnt: cycle %0d got %0d required %0d", c, O_CNT, exp.cnt); end
      if (O_OVF !== exp.ovf) begin errors++; $display("FAIL bp_ovf: cycle %0d got %b required %b", c, O_OVF, exp.ovf); end
      @(negedge CLK);
    end
    sb.push_back('{dat: 72'd4, cnt: 16'd1, ovf: 1'b0});
    do_ack();
    @(negedge CLK);
    checks += 3;
    if (O_STB !== 1'b0) begin errors++; $display("FAIL bp_release_stb: got %b required 0", O_STB); end
    if (I_ACK !== 1'b1) begin errors++; $display("FAIL bp_release_ack: got %b required 1", I_ACK); end
    if (O_DAT !== 72'd300) begin errors++; $display("FAIL bp_dat_kept: got %h required %h", O_DAT, 72'd300); end
    @(posedge CLK); #1;
    I_STB = 1'b0; I_LAST = 1'b0;
    @(negedge CLK);
    checks++;
    if (O_STB !== 1'b1) begin errors++; $display("FAIL bp_new_latency: O_STB=%b required 1", O_STB); end
    exp = sb.pop_front();
    checks += 3;
    if (O_DAT !== exp.dat) begin errors++; $display("FAIL bp_new_dat: got %h required %h", O_DAT, exp.dat); end
    if (O_CNT !== exp.cnt) begin errors++; $display("FAIL bp_new_cnt: got %0d required %0d", O_CNT, exp.cnt); end
    if (O_OVF !== exp.ovf) begin errors++; $display("FAIL bp_new_ovf: got %b required %b", O_OVF, exp.ovf); end
    do_ack();
  endtask

  task automatic test_overflow(input int beats);
    res_t exp;
    bit ok;
    logic [72:0] model;
    logic        movf;
    model = '0; movf = 1'b0;
    for (int i = 0; i < beats; i++) begin
      model = {1'b0, model[71:0]} + {9'd0, ALL_ONES};
      movf  = movf | model[72];
    end
    sb.push_back('{dat: model[71:0], cnt: 16'(beats), ovf: movf});
    for (int i = 0; i < beats; i++) send_beat(ALL_ONES, (i == beats - 1));
    I_STB = 1'b0; I_LAST = 1'b0;
    wait_result(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout: beats %0d O_STB=%b required 1", beats, O_STB); end
    exp = sb.pop_front();
    checks += 3;
    if (O_DAT !== exp.dat) begin errors++; $display("FAIL ovf_dat: beats %0d got %h required %h", beats, O_DAT, exp.dat); end
    if (O_CNT !== exp.cnt) begin errors++; $display("FAIL ovf_cnt: beats %0d got %0d required %0d", beats, O_CNT, exp.cnt); end
    if (O_OVF !== exp.ovf) begin errors++; $display("FAIL ovf_flag: beats %0d got %b required %b", beats, O_OVF, exp.ovf); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    res_t exp;
    bit ok;
    send_beat(64'd100, 1'b0);
    send_beat(64'd100, 1'b0);
    I_STB = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    sb.push_back('{dat: 72'd9, cnt: 16'd1, ovf: 1'b0});
    send_beat(64'd9, 1'b1);
    I_STB = 1'b0; I_LAST = 1'b0;
    wait_result(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: O_STB=%b required 1", O_STB); end
    exp = sb.pop_front();
    checks += 3;
    if (O_DAT !== exp.dat) begin errors++; $display("FAIL midrst_dat: got %h required %h", O_DAT, exp.dat); end
    if (O_CNT !== exp.cnt) begin errors++; $display("FAIL midrst_cnt: got %0d required %0d", O_CNT, exp.cnt); end
    if (O_OVF !== exp.ovf) begin errors++; $display("FAIL midrst_ovf: got %b required %b", O_OVF, exp.ovf); end
    do_ack();
  endtask

  initial begin
    RST = 1'b0; I_STB = 1'b0; I_DAT = '0; I_LAST = 1'b0; O_ACK = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_backpressure();
    test_overflow(256);
    test_overflow(257);
    test_reset_mid_frame();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
